// File: rtl/rcc_rtc_src_switch_ctrl.sv
// rcc_rtc_src_switch_ctrl
//   Sequences RTC kernel clock source changes. The kernel clock is gated off,
//   the new source is committed, the mux is given time to settle, and the
//   clock is re-enabled once the selected source reports ready. A committed
//   non-zero source is locked until the backup domain is reset. An LSE clock
//   security failure while LSE is selected forces a sticky fault state.
//
// Ports
//   clk          in   controller clock
//   rst_n        in   synchronous active-low reset
//   bdrst        in   backup-domain soft reset, synchronous active-high
//   req_vld      in   source-change request valid
//   req_rdy      out  request accepted when req_vld & req_rdy
//   req_sel[1:0] in   requested source: 00 none, 01 LSE, 10 LSI, 11 HSE_RTC
//   req_en       in   requested rtcen after the switch
//   src_rdy[3:0] in   per-source ready, indexed by select ([0] unused)
//   lsecss_fail  in   LSE clock security failure (already synchronised)
//   rtcsel[1:0]  out  committed source select
//   rtcen        out  RTC kernel clock enable
//   busy         out  sequence in progress
//   done         out  1-cycle pulse, request completed OK
//   err          out  1-cycle pulse, request rejected or failed
//   err_code[1:0] out 00 NOSRC, 01 LOCKED, 10 TIMEOUT, 11 FAULT (held)
//   locked       out  non-zero source committed
//   css_fault    out  sticky LSE CSS fault
module rcc_rtc_src_switch_ctrl #(
  parameter int GATE_WAIT   = 4,
  parameter int SETTLE_WAIT = 8,
  parameter int RDY_TIMEOUT = 1024,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bdrst,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [1:0]       req_sel,
  input  logic             req_en,
  input  logic [3:0]       src_rdy,
  input  logic             lsecss_fail,
  output logic [1:0]       rtcsel,
  output logic             rtcen,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             locked,
  output logic             css_fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_GATE_OFF, S_SWITCH, S_SETTLE, S_WAIT_RDY, S_FAULT
  } state_t;

  localparam logic [1:0] EC_NOSRC   = 2'b00;
  localparam logic [1:0] EC_LOCKED  = 2'b01;
  localparam logic [1:0] EC_TIMEOUT = 2'b10;
  localparam logic [1:0] EC_FAULT   = 2'b11;

  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_WAIT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_WAIT - 1);
  localparam logic [CNT_W-1:0] RDY_LAST    = CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       req_sel_reg, req_sel_next;
  logic             req_en_reg, req_en_next;
  logic [1:0]       rtcsel_reg, rtcsel_next;
  logic             rtcen_reg, rtcen_next;
  logic             done_next, err_next;
  logic [1:0]       err_code_reg, err_code_next;
  logic             locked_reg, locked_next;
  logic             css_fault_reg, css_fault_next;
  logic             busy_reg, done_reg, err_reg, req_rdy_reg;
  logic             accept;

  // The registered ready is additionally masked by bdrst so a request
  // presented in the same cycle as a backup-domain reset is never accepted.
  assign req_rdy = req_rdy_reg && !bdrst;
  assign accept  = req_vld && req_rdy;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    req_sel_next   = req_sel_reg;
    req_en_next    = req_en_reg;
    rtcsel_next    = rtcsel_reg;
    rtcen_next     = rtcen_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    err_code_next  = err_code_reg;
    locked_next    = locked_reg;
    css_fault_next = css_fault_reg;

    if (lsecss_fail && rtcsel_reg == 2'b01) begin
      // Abort whatever is in flight; selection and lock are left alone.
      state_next     = S_FAULT;
      rtcen_next     = 1'b0;
      css_fault_next = 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            // Decide on the request as presented; keep a copy for later states.
            req_sel_next = req_sel;
            req_en_next  = req_en;
            if (locked_reg && req_sel != rtcsel_reg) begin
              err_next      = 1'b1;
              err_code_next = EC_LOCKED;
            end else if (req_sel == rtcsel_reg) begin
              if (!req_en) begin
                rtcen_next = 1'b0;
                done_next  = 1'b1;
              end else if (rtcsel_reg == 2'b00) begin
                rtcen_next    = 1'b0;
                err_next      = 1'b1;
                err_code_next = EC_NOSRC;
              end else begin
                state_next = S_WAIT_RDY;
                cnt_next   = '0;
              end
            end else begin
              state_next = S_GATE_OFF;
              cnt_next   = '0;
              rtcen_next = 1'b0;
            end
          end
        end
        S_GATE_OFF: begin
          // The select is committed on the way into SWITCH so it is visible
          // while SWITCH is the current state.
          if (cnt_reg == GATE_LAST) begin
            state_next  = S_SWITCH;
            rtcsel_next = req_sel_reg;
            locked_next = |req_sel_reg;
          end
        end
        S_SWITCH: begin
          state_next = S_SETTLE;
          cnt_next   = '0;
        end
        S_SETTLE: begin
          if (cnt_reg == SETTLE_LAST) begin
            if (!req_en_reg) begin
              done_next  = 1'b1;
              state_next = S_IDLE;
            end else begin
              state_next = S_WAIT_RDY;
              cnt_next   = '0;
            end
          end
        end
        S_WAIT_RDY: begin
          if (src_rdy[rtcsel_reg]) begin
            rtcen_next = 1'b1;
            done_next  = 1'b1;
            state_next = S_IDLE;
          end else if (cnt_reg == RDY_LAST) begin
            err_next      = 1'b1;
            err_code_next = EC_TIMEOUT;
            state_next    = S_IDLE;
          end
        end
        S_FAULT: begin
          if (accept) begin
            err_next      = 1'b1;
            err_code_next = EC_FAULT;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bdrst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      req_sel_reg   <= 2'b00;
      req_en_reg    <= 1'b0;
      rtcsel_reg    <= 2'b00;
      rtcen_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_code_reg  <= 2'b00;
      locked_reg    <= 1'b0;
      css_fault_reg <= 1'b0;
      req_rdy_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      req_sel_reg   <= req_sel_next;
      req_en_reg    <= req_en_next;
      rtcsel_reg    <= rtcsel_next;
      rtcen_reg     <= rtcen_next;
      busy_reg      <= (state_next != S_IDLE) && (state_next != S_FAULT);
      done_reg      <= done_next;
      err_reg       <= err_next;
      err_code_reg  <= err_code_next;
      locked_reg    <= locked_next;
      css_fault_reg <= css_fault_next;
      req_rdy_reg   <= (state_next == S_IDLE) || (state_next == S_FAULT);
    end
  end

  assign rtcsel    = rtcsel_reg;
  assign rtcen     = rtcen_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;
  assign locked    = locked_reg;
  assign css_fault = css_fault_reg;

endmodule

// File: tb/tb_rcc_rtc_src_switch_ctrl.sv
// Directed testbench for rcc_rtc_src_switch_ctrl. Inputs change 1 ns after
// the rising edge, outputs are checked at the same point.
module tb_rcc_rtc_src_switch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, bdrst, req_vld, req_en, lsecss_fail;
  logic [1:0] req_sel;
  logic [3:0] src_rdy;
  logic       req_rdy, rtcen, busy, done, err, locked, css_fault;
  logic [1:0] rtcsel, err_code;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  always #5 clk = ~clk;

  rcc_rtc_src_switch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bdrst(bdrst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_sel(req_sel), .req_en(req_en),
    .src_rdy(src_rdy), .lsecss_fail(lsecss_fail),
    .rtcsel(rtcsel), .rtcen(rtcen), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .locked(locked), .css_fault(css_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rtcsel"}, rtcsel, 0);
    chk({tag, ".rtcen"}, rtcen, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".err_code"}, err_code, 0);
    chk({tag, ".locked"}, locked, 0);
    chk({tag, ".css_fault"}, css_fault, 0);
    chk({tag, ".req_rdy"}, req_rdy, 0);
  endtask

  // Present one request for a single cycle; returns positioned at t0+1.
  task automatic send(input logic [1:0] sel, input logic en);
    req_vld = 1'b1; req_sel = sel; req_en = en;
    tick();
    req_vld = 1'b0;
  endtask

  // Wait (bounded) for done or err; cyc holds the cycle offset from t0.
  task automatic wait_result(input int limit);
    cyc = 1;
    while (!(done || err) && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_bdrst();
    bdrst = 1'b1;
    tick();
    bdrst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bdrst = 1'b0; req_vld = 1'b0; req_sel = 2'b00; req_en = 1'b0;
    src_rdy = 4'b0000; lsecss_fail = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(); tick();
    chk("post_reset.req_rdy", req_rdy, 1);

    // Source none with enable: NOSRC error, clock stays off.
    send(2'b00, 1'b1);
    chk("nosrc.err", err, 1);
    chk("nosrc.code", err_code, 2'b00);
    chk("nosrc.rtcen", rtcen, 0);
    chk("nosrc.done", done, 0);
    tick();
    // Source none without enable: completes immediately.
    send(2'b00, 1'b0);
    chk("none_off.done", done, 1);
    chk("none_off.err", err, 0);
    tick();

    // Test 1: switch to LSE; src_rdy[1] already high.
    src_rdy = 4'b0010;
    send(2'b01, 1'b1);
    chk("t1.busy", busy, 1);
    chk("t1.req_rdy", req_rdy, 0);
    for (int c = 1; c <= 14; c++) begin
      if (c == 4) begin
        chk("t1.rtcsel_before", rtcsel, 2'b00);
        chk("t1.locked_before", locked, 0);
      end
      if (c == 5) begin
        chk("t1.rtcsel_commit", rtcsel, 2'b01);
        chk("t1.locked_commit", locked, 1);
      end
      chk($sformatf("t1.rtcen_c%0d", c), rtcen, 0);
      chk($sformatf("t1.done_c%0d", c), done, 0);
      tick();
    end
    // now at t0+15
    chk("t1.rtcen", rtcen, 1);
    chk("t1.done", done, 1);
    chk("t1.err", err, 0);
    chk("t1.busy_end", busy, 0);
    tick();
    chk("t1.done_pulse", done, 0);

    // Test 2: locked, request HSE.
    send(2'b11, 1'b1);
    chk("t2.err", err, 1);
    chk("t2.code", err_code, 2'b01);
    chk("t2.rtcsel", rtcsel, 2'b01);
    chk("t2.rtcen", rtcen, 1);
    chk("t2.done", done, 0);
    tick();
    chk("t2.code_held", err_code, 2'b01);
    chk("t2.err_pulse", err, 0);

    // Test 6: same source, disable then enable.
    send(2'b01, 1'b0);
    chk("t6.rtcen_off", rtcen, 0);
    chk("t6.done_off", done, 1);
    tick();
    send(2'b01, 1'b1);
    chk("t6.busy", busy, 1);
    chk("t6.done_early", done, 0);
    tick();
    chk("t6.rtcen_on", rtcen, 1);
    chk("t6.done_on", done, 1);
    tick();

    // Test 4: LSE CSS failure, then FAULT behaviour and bdrst recovery.
    lsecss_fail = 1'b1;
    tick();
    lsecss_fail = 1'b0;
    chk("t4.rtcen", rtcen, 0);
    chk("t4.css_fault", css_fault, 1);
    chk("t4.req_rdy", req_rdy, 1);
    chk("t4.rtcsel", rtcsel, 2'b01);
    chk("t4.locked", locked, 1);
    chk("t4.busy", busy, 0);
    send(2'b01, 1'b1);
    chk("t4.err", err, 1);
    chk("t4.code", err_code, 2'b11);
    chk("t4.done", done, 0);
    chk("t4.css_sticky", css_fault, 1);
    bdrst = 1'b1;
    #1;
    chk("t4.req_rdy_bdrst", req_rdy, 0);
    tick();
    chk_all_zero("t4.bdrst");
    bdrst = 1'b0;
    tick(); tick();
    src_rdy = 4'b1000;
    send(2'b11, 1'b1);
    wait_result(40);
    chk("t4.hse_cycles", cyc, 15);
    chk("t4.hse_done", done, 1);
    chk("t4.hse_rtcen", rtcen, 1);
    chk("t4.hse_rtcsel", rtcsel, 2'b11);
    tick();

    // Test 5: bdrst together with a request while in SETTLE.
    do_bdrst();
    tick();
    src_rdy = 4'b0010;
    send(2'b01, 1'b1);
    repeat (7) tick();            // t0+8, inside SETTLE
    chk("t5.busy_settle", busy, 1);
    bdrst = 1'b1; req_vld = 1'b1; req_sel = 2'b11; req_en = 1'b1;
    #1;
    chk("t5.req_rdy", req_rdy, 0);
    tick();
    bdrst = 1'b0; req_vld = 1'b0;
    chk("t5.busy", busy, 0);
    chk("t5.rtcsel", rtcsel, 2'b00);
    chk("t5.done", done, 0);
    chk("t5.err", err, 0);
    tick();
    chk("t5.done2", done, 0);
    chk("t5.err2", err, 0);
    chk("t5.busy2", busy, 0);
    tick();

    // Test 3: LSI never ready -> timeout after 1024 cycles in WAIT_RDY.
    do_bdrst();
    tick();
    src_rdy = 4'b0000;
    send(2'b10, 1'b1);
    wait_result(1200);
    chk("t3.cycles", cyc, 1038);
    chk("t3.err", err, 1);
    chk("t3.code", err_code, 2'b10);
    chk("t3.done", done, 0);
    chk("t3.rtcen", rtcen, 0);
    chk("t3.rtcsel", rtcsel, 2'b10);
    chk("t3.locked", locked, 1);
    tick();
    chk("t3.busy_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
